alu_shift_pipe: RTL and testbench

Parametrised, 2-stage pipelined execute unit for the core. It combines the shift-operand path (LSL/LSR/ASR, optional ROR) with the data-processing ops ADD/ADC/SUB/SBC/AND/ORR/EOR/BIC/MOV_LAS. It owns the architectural NZCV register and sits between control-unit issue and register-file writeback, using a valid/ready handshake on both sides.

---
 rtl/alu_shift_pipe_if.sv | 40 ++++
 rtl/alu_shift_pipe.sv | 189 ++++++++++++++++++
 tb/tb_alu_shift_pipe.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_shift_pipe_if.sv
// Issue/result bus of the alu_shift_pipe execute unit.
// master = issuing/consuming side, slave = the execute unit itself.
interface alu_shift_pipe_if #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8,
  parameter int IMM_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        op;
  logic              s_en;
  logic              imm_en;
  logic [1:0]        stype;
  logic [DATA_W-1:0] rn;
  logic [DATA_W-1:0] rm;
  logic [AMT_W-1:0]  rs;
  logic [IMM_W-1:0]  imm_shift;
  logic              flag_ld;
  logic [3:0]        flag_ld_val;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] rd;
  logic              rd_we;
  logic              out_n;
  logic              out_z;
  logic              out_c;
  logic              out_v;

  modport master (
    output in_valid, op, s_en, imm_en, stype, rn, rm, rs, imm_shift,
           flag_ld, flag_ld_val, out_ready,
    input  in_ready, out_valid, rd, rd_we, out_n, out_z, out_c, out_v
  );

  modport slave (
    input  in_valid, op, s_en, imm_en, stype, rn, rm, rs, imm_shift,
           flag_ld, flag_ld_val, out_ready,
    output in_ready, out_valid, rd, rd_we, out_n, out_z, out_c, out_v
  );
endinterface

// File: rtl/alu_shift_pipe.sv
// Two-stage execute unit: stage 1 = barrel shifter, stage 2 = ALU + NZCV.
// Elastic valid/ready pipeline, one issue per cycle, two-cycle latency.
// Optional rotate (stype=11) is built only when ALU_ROR_EN is defined;
// otherwise stype=11 passes rm through with the carry kept.
module alu_shift_pipe #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8,
  parameter int IMM_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  alu_shift_pipe_if.slave  bus
);
  localparam int N_W = ((AMT_W > IMM_W) ? AMT_W : IMM_W) + 1;
  localparam logic [N_W-1:0] N_DW = N_W'(DATA_W);
  localparam int MSB = DATA_W - 1;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_ADC = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_SBC = 5'h03;
  localparam logic [4:0] OP_AND = 5'h04;
  localparam logic [4:0] OP_ORR = 5'h05;
  localparam logic [4:0] OP_EOR = 5'h06;
  localparam logic [4:0] OP_BIC = 5'h07;
  localparam logic [4:0] OP_MOV = 5'h08;

  logic [N_W-1:0]    n;
  logic [IMM_W-1:0]  sh;
  logic [IMM_W-1:0]  idx_lsl;
  logic [IMM_W-1:0]  idx_lsr;
  logic [DATA_W-1:0] sh_res;
  logic              sh_c;
  logic              sh_keep;

  logic              s1_valid;
  logic [4:0]        s1_op;
  logic              s1_s_en;
  logic [DATA_W-1:0] s1_rn;
  logic [DATA_W-1:0] s1_op2;
  logic              s1_sh_c;
  logic              s1_keep;

  logic              s2_adv;
  logic [3:0]        nzcv;
  logic              legal;
  logic              c_eff;
  logic [DATA_W-1:0] b_opnd;
  logic              cin;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;

  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign {bus.out_n, bus.out_z, bus.out_c, bus.out_v} = nzcv;

  // Stage 1: shift amount select and barrel shifter with carry-out.
  always_comb begin
    n       = bus.imm_en ? N_W'(bus.imm_shift) : N_W'(bus.rs);
    sh      = n[IMM_W-1:0];
    idx_lsl = IMM_W'(0) - sh;
    idx_lsr = sh - IMM_W'(1);
    sh_res  = bus.rm;
    sh_c    = 1'b0;
    sh_keep = 1'b1;
    if (n != '0) begin
      sh_keep = 1'b0;
      case (bus.stype)
        2'b00: begin
          if (n < N_DW) begin
            sh_res = bus.rm << sh;
            sh_c   = bus.rm[idx_lsl];
          end else begin
            sh_res = '0;
            sh_c   = (n == N_DW) ? bus.rm[0] : 1'b0;
          end
        end
        2'b01: begin
          if (n < N_DW) begin
            sh_res = bus.rm >> sh;
            sh_c   = bus.rm[idx_lsr];
          end else begin
            sh_res = '0;
            sh_c   = (n == N_DW) ? bus.rm[MSB] : 1'b0;
          end
        end
        2'b10: begin
          if (n < N_DW) begin
            sh_res = $signed(bus.rm) >>> sh;
            sh_c   = bus.rm[idx_lsr];
          end else begin
            sh_res = {DATA_W{bus.rm[MSB]}};
            sh_c   = bus.rm[MSB];
          end
        end
        2'b11: begin
`ifdef ALU_ROR_EN
          // sh = n mod DATA_W; sh = 0 collapses to rm with carry = rm MSB.
          sh_res = (bus.rm >> sh) | (bus.rm << idx_lsl);
          sh_c   = sh_res[MSB];
`else
          sh_keep = 1'b1;
`endif
        end
      endcase
    end
  end

  // Stage 1 register: capture shifter output on accept, hold on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_s_en  <= 1'b0;
      s1_rn    <= '0;
      s1_op2   <= '0;
      s1_sh_c  <= 1'b0;
      s1_keep  <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op    <= bus.op;
        s1_s_en  <= bus.s_en;
        s1_rn    <= bus.rn;
        s1_op2   <= sh_res;
        s1_sh_c  <= sh_c;
        s1_keep  <= sh_keep;
      end
    end
  end

  // Stage 2: ALU. A kept shifter carry resolves against the live C flag,
  // which already reflects any older flag-setting op (program order).
  always_comb begin
    legal   = (s1_op <= OP_MOV);
    c_eff   = s1_keep ? nzcv[1] : s1_sh_c;
    b_opnd  = s1_op2;
    cin     = 1'b0;
    case (s1_op)
      OP_ADC: cin = nzcv[1];
      OP_SUB: begin b_opnd = ~s1_op2; cin = 1'b1;    end
      OP_SBC: begin b_opnd = ~s1_op2; cin = nzcv[1]; end
      default: ;
    endcase
    sum     = {1'b0, s1_rn} + {1'b0, b_opnd} + {{DATA_W{1'b0}}, cin};
    alu_res = sum[MSB:0];
    alu_c   = sum[DATA_W];
    alu_v   = (s1_rn[MSB] == b_opnd[MSB]) && (alu_res[MSB] != s1_rn[MSB]);
    case (s1_op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: ;
      default: begin
        alu_c = c_eff;
        alu_v = nzcv[0];
        case (s1_op)
          OP_AND:  alu_res = s1_rn & s1_op2;
          OP_ORR:  alu_res = s1_rn | s1_op2;
          OP_EOR:  alu_res = s1_rn ^ s1_op2;
          OP_BIC:  alu_res = s1_rn & ~s1_op2;
          OP_MOV:  alu_res = s1_op2;
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // Stage 2 register and NZCV: outputs are driven straight from here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.rd        <= '0;
      bus.rd_we     <= 1'b0;
      nzcv          <= 4'b0000;
    end else begin
      if (s2_adv) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.rd    <= legal ? alu_res : '0;
          bus.rd_we <= legal;
        end
      end
      if (bus.flag_ld)
        nzcv <= bus.flag_ld_val;
      else if (s2_adv && s1_valid && s1_s_en && legal)
        nzcv <= {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
    end
  end
endmodule

// File: tb/tb_alu_shift_pipe.sv
// Directed + short random bench for alu_shift_pipe with a result scoreboard.
module tb_alu_shift_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_shift_pipe_if #(.DATA_W(32), .AMT_W(8), .IMM_W(5)) bus();
  alu_shift_pipe #(.DATA_W(32), .AMT_W(8), .IMM_W(5)) dut (
    .clk(clk), .rst(rst_n), .bus(bus));

  typedef struct packed {
    logic [4:0] op; logic s_en; logic imm_en; logic [1:0] stype;
    logic [31:0] rn; logic [31:0] rm; logic [7:0] rs; logic [4:0] imm;
  } vec_t;
  typedef struct packed { logic [31:0] rd; logic we; logic [3:0] nzcv; } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_nzcv = 4'b0000;
  int         n_vec = 0;
  int         n_err = 0;
  bit         auto_rel = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic s_en, input logic imm_en,
                              input logic [1:0] stype, input logic [31:0] rn,
                              input logic [31:0] rm, input logic [7:0] rs, input logic [4:0] imm);
    vec_t v;
    v.op = op; v.s_en = s_en; v.imm_en = imm_en; v.stype = stype;
    v.rn = rn; v.rm = rm; v.rs = rs; v.imm = imm;
    return v;
  endfunction

  // Reference shifter built on 64-bit windows / bitwise rotation.
  function automatic void model_shift(input vec_t v, input logic ckeep,
                                      output logic [31:0] op2, output logic sc);
    int n;
    int k;
    logic [63:0] t;
    n = v.imm_en ? int'(v.imm) : int'(v.rs);
    op2 = v.rm;
    sc = ckeep;
    if (n != 0) begin
      case (v.stype)
        2'd0: if (n <= 32) begin t = {32'b0, v.rm} << n; op2 = t[31:0]; sc = t[32]; end
              else begin op2 = '0; sc = 1'b0; end
        2'd1: if (n <= 32) begin t = {v.rm, 32'b0} >> n; op2 = t[63:32]; sc = t[31]; end
              else begin op2 = '0; sc = 1'b0; end
        2'd2: begin
          k = (n > 32) ? 32 : n;
          t = $signed({v.rm, 32'b0}) >>> k;
          op2 = t[63:32];
          sc = t[31];
        end
        2'd3: begin
`ifdef ALU_ROR_EN
          for (int i = 0; i < n; i++) begin
            sc = op2[0];
            op2 = {op2[0], op2[31:1]};
          end
`endif
        end
      endcase
    end
  endfunction

  // Reference ALU in program order; pushes the expected output record.
  function automatic void model_push(input vec_t v);
    logic [31:0] op2, res;
    logic sc, c, vf, legal;
    longint ru, rs_s, ci;
    exp_t e;
    model_shift(v, m_nzcv[1], op2, sc);
    c = sc; vf = m_nzcv[0]; res = '0;
    ci = longint'(m_nzcv[1]);
    case (v.op)
      5'h00, 5'h01: begin
        if (v.op == 5'h00) ci = 0;
        ru = longint'(v.rn) + longint'(op2) + ci;
        rs_s = longint'($signed(v.rn)) + longint'($signed(op2)) + ci;
        res = ru[31:0]; c = ru[32];
        vf = (rs_s > 64'sd2147483647) || (rs_s < -64'sd2147483648);
      end
      5'h02, 5'h03: begin
        if (v.op == 5'h02) ci = 1;
        ru = longint'(v.rn) - longint'(op2) - (1 - ci);
        rs_s = longint'($signed(v.rn)) - longint'($signed(op2)) - (1 - ci);
        res = ru[31:0]; c = (ru >= 0);
        vf = (rs_s > 64'sd2147483647) || (rs_s < -64'sd2147483648);
      end
      5'h04: res = v.rn & op2;
      5'h05: res = v.rn | op2;
      5'h06: res = v.rn ^ op2;
      5'h07: res = v.rn & ~op2;
      5'h08: res = op2;
      default: res = '0;
    endcase
    legal = (v.op <= 5'h08);
    if (legal && v.s_en) m_nzcv = {res[31], (res == 32'h0), c, vf};
    e.rd = legal ? res : 32'h0;
    e.we = legal;
    e.nzcv = m_nzcv;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1; bus.op = v.op; bus.s_en = v.s_en; bus.imm_en = v.imm_en;
    bus.stype = v.stype; bus.rn = v.rn; bus.rm = v.rm; bus.rs = v.rs; bus.imm_shift = v.imm;
  endtask

  task automatic issue(input vec_t v);
    logic ok;
    ok = 1'b0;
    drive(v);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
      if (!ok && auto_rel) bus.out_ready = 1'b1;
    end
    if (ok) model_push(v);
    check("issue_accept", 32'(ok), 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: pop and compare on every result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("spurious_output", 32'(bus.out_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("rd", bus.rd, e.rd);
        check("rd_we", 32'(bus.rd_we), 32'(e.we));
        check("nzcv", 32'({bus.out_n, bus.out_z, bus.out_c, bus.out_v}), 32'(e.nzcv));
      end
    end
  end

  initial begin
    vec_t sv[4];
    vec_t v;
    int acc;
    logic ok;
    int r;
    bus.in_valid = 0; bus.op = 0; bus.s_en = 0; bus.imm_en = 0; bus.stype = 0;
    bus.rn = 0; bus.rm = 0; bus.rs = 0; bus.imm_shift = 0;
    bus.flag_ld = 0; bus.flag_ld_val = 0; bus.out_ready = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rd", bus.rd, 32'h0);
    check("rst_rd_we", 32'(bus.rd_we), 32'd0);
    check("rst_nzcv", 32'({bus.out_n, bus.out_z, bus.out_c, bus.out_v}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADD overflow, with latency check (out_valid two cycles after accept)
    drive(mk(5'h00, 1, 1, 2'b00, 32'h7FFFFFFF, 32'h1, 8'd0, 5'd0));
    @(posedge clk); #1;
    model_push(mk(5'h00, 1, 1, 2'b00, 32'h7FFFFFFF, 32'h1, 8'd0, 5'd0));
    idle();
    check("lat_t1_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_t2_out_valid", 32'(bus.out_valid), 32'd1);
    drain();

    // SUB sets C, back-to-back ADC consumes it
    issue(mk(5'h02, 1, 1, 2'b00, 32'd5, 32'd5, 8'd0, 5'd0));
    issue(mk(5'h01, 0, 1, 2'b00, 32'd1, 32'd1, 8'd0, 5'd0));
    idle(); drain();

    // LSL by 32 and 33, ASR by 4, ROR by 36, LSR by 32 and 1
    issue(mk(5'h08, 1, 0, 2'b00, 32'h0, 32'h80000001, 8'd32, 5'd0));
    issue(mk(5'h08, 1, 0, 2'b00, 32'h0, 32'h80000001, 8'd33, 5'd0));
    issue(mk(5'h08, 1, 1, 2'b10, 32'h0, 32'hF0000000, 8'd0, 5'd4));
    issue(mk(5'h08, 1, 0, 2'b11, 32'h0, 32'h0000000F, 8'd36, 5'd0));
    issue(mk(5'h08, 1, 0, 2'b01, 32'h0, 32'h80000000, 8'd32, 5'd0));
    issue(mk(5'h08, 1, 1, 2'b01, 32'h0, 32'h00000003, 8'd0, 5'd1));
    issue(mk(5'h08, 1, 0, 2'b10, 32'h0, 32'h80000000, 8'd200, 5'd0));
    issue(mk(5'h08, 1, 0, 2'b11, 32'h0, 32'h80000001, 8'd32, 5'd0));
    idle(); drain();

    // Back-pressure: out_ready low for 3 cycles while issuing 4 ops
    sv[0] = mk(5'h00, 1, 1, 2'b00, 32'd10, 32'd1, 8'd0, 5'd0);
    sv[1] = mk(5'h05, 1, 1, 2'b00, 32'hF0, 32'h0F, 8'd0, 5'd0);
    sv[2] = mk(5'h06, 0, 1, 2'b00, 32'hFF, 32'h1, 8'd0, 5'd4);
    sv[3] = mk(5'h07, 1, 1, 2'b00, 32'hFF, 32'h3, 8'd0, 5'd0);
    bus.out_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      drive(sv[acc]);
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
      if (ok) begin model_push(sv[acc]); acc++; end
    end
    check("stall_accepts", 32'(acc), 32'd2);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    for (int k = 2; k < 4; k++) issue(sv[k]);
    idle(); drain();

    // Illegal op, then ADD whose S1->S2 transfer coincides with flag_ld
    issue(mk(5'h1F, 1, 1, 2'b00, 32'h0, 32'h0, 8'd0, 5'd0));
    issue(mk(5'h00, 1, 1, 2'b00, 32'h0, 32'h0, 8'd0, 5'd0));
    idle();
    bus.flag_ld = 1'b1; bus.flag_ld_val = 4'b1010;
    exp_q[exp_q.size()-1].nzcv = 4'b1010;
    m_nzcv = 4'b1010;
    @(posedge clk); #1;
    bus.flag_ld = 1'b0;
    drain();
    check("flag_ld_nzcv", 32'({bus.out_n, bus.out_z, bus.out_c, bus.out_v}), 32'hA);
    // KEEP carry picks up the force-loaded C
    issue(mk(5'h08, 1, 1, 2'b00, 32'h0, 32'h0, 8'd0, 5'd0));
    idle(); drain();

    // Random stream with random back-pressure
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      v = mk((r == 9) ? 5'h1F : 5'(r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom, $urandom, 8'($urandom_range(0, 40)),
             5'($urandom_range(0, 31)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      issue(v);
      if ($urandom_range(0, 3) == 0) begin idle(); @(posedge clk); #1; end
    end
    idle(); drain();

    // Reset with two entries in flight: both discarded
    bus.out_ready = 1'b0;
    issue(mk(5'h00, 1, 1, 2'b00, 32'h1, 32'h1, 8'd0, 5'd0));
    issue(mk(5'h02, 1, 1, 2'b00, 32'h1, 32'h2, 8'd0, 5'd0));
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_nzcv", 32'({bus.out_n, bus.out_z, bus.out_c, bus.out_v}), 32'd0);
    exp_q.delete();
    m_nzcv = 4'b0000;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_no_output", 32'(bus.out_valid), 32'd0);
    issue(mk(5'h00, 1, 1, 2'b00, 32'h3, 32'h4, 8'd0, 5'd0));
    idle(); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
